setpoint_ramp_ctrl: RTL
=======================

# setpoint_ramp_ctrl

Front-end controller for the 10-bit DPWM current setpoint. Takes the raw up/down push-buttons and synchronizes, debounces and arbitrates them, with press-and-hold auto-repeat. It maintains a saturating target value and slews the published setpoint toward that target one LSB at a time, so the PWM stage never sees a step larger than 1 LSB. It sits between the board buttons and the DPWM comparator and replaces direct button-driven counting.

## Interface
- DEB_CYCLES, 4, consecutive stable samples required before a debounced button changes state
- HOLD_CYCLES, 20, cycles from first step to first auto-repeat step
- REP_CYCLES, 5, cycles between auto-repeat steps
- STEP, 8, target increment/decrement per step (1..255)
- MIN_VAL, 0, lower saturation limit of target
- MAX_VAL, 1000, upper saturation limit of target (MIN_VAL < MAX_VAL ≤ 1023)
- RAMP_DIV, 2, cycles per ramp tick (≥1)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- enable  in  1  1 = accept button steps and run ramp; 0 = freeze
- boton_aumento  in  1  raw, asynchronous up button, active-high
- boton_disminuye  in  1  raw, asynchronous down button, active-high
- cant_objetivo  out  10  target setpoint
- cant_corriente  out  10  ramped setpoint driven to the DPWM
- en_rampa  out  1  1 while cant_corriente ≠ cant_objetivo
- pulso_cambio  out  1  one-cycle pulse when cant_objetivo changes value

## Operation
- Reset values: cant_objetivo = cant_corriente = MIN_VAL; en_rampa = 0; pulso_cambio = 0; synchronizers, debounced states, all counters 0; FSM in IDLE.
- Each button passes through a 2-flop synchronizer, then a debouncer. The debounce counter increments while the synchronized value ≠ the debounced value and clears when they are equal. The debounced value flips when the counter reaches DEB_CYCLES.
- Command: UP when only debounced up is high; DN when only debounced down is high; NONE otherwise (both high counts as NONE).
- Repeat FSM:
  - IDLE: on UP/DN, issue one step → HOLD and load the timer with HOLD_CYCLES.
  - HOLD: command unchanged, timer expired → step, REPEAT, load REP_CYCLES. Command changed → IDLE.
  - REPEAT: command unchanged, timer expired → step, reload REP_CYCLES. Command changed → IDLE.
  - Returning to IDLE when the new command is UP/DN counts as a fresh press: the step is issued on the following cycle.
- Step arithmetic is done in 11 bits.
  - UP: target = min(target+STEP, MAX_VAL).
  - DN: target = (target < MIN_VAL+STEP) ? MIN_VAL : target−STEP.
  - pulso_cambio is asserted only if the new value differs from the old; a saturated step produces no pulse.
- Ramp: a prescaler counts 0..RAMP_DIV−1 and ticks at the wrap. On a tick, cant_corriente moves ±1 toward cant_objetivo, or holds if equal. cant_corriente never overshoots.
- enable = 0:
  - FSM is forced to IDLE and no steps are issued.
  - The prescaler and cant_corriente hold.
  - The debouncers keep running.
  - A button still held when enable rises is treated as a fresh press.

## Timing
- Raw button rising edge (held stable) → cant_objetivo updated at the edge DEB_CYCLES+3 cycles later: 2 sync + DEB_CYCLES debounce + 1 step register.
- pulso_cambio is high in the same cycle in which cant_objetivo shows the new value.
- Holding one button: steps at t0, t0+HOLD_CYCLES, then every REP_CYCLES.
- Ramp slew rate: 1 LSB per RAMP_DIV cycles. en_rampa is combinational from the two registered outputs.
- A step and a ramp tick in the same cycle: the ramp compares against the old target; the new target takes effect from the next tick.
- Reset asserted mid-ramp or mid-hold: all outputs return to reset values asynchronously. After release, nothing moves until a fresh debounced press.

## Test plan
Use the default parameters and assert reset for 3 cycles before each scenario.
1. Up held 10 cycles after reset → cant_objetivo 0→8 exactly 7 cycles after sampling, one pulso_cambio. cant_corriente reaches 8 after 16 cycles, then en_rampa = 0.
2. Up toggled with pulses of 1–3 cycles for 40 cycles → no debounced change, cant_objetivo stays 0, no pulso_cambio.
3. Up held 60 cycles past first step → steps at t0, +20, +25, … +60: target 8·10 = 80 and exactly 10 pulses. Down held afterward decrements from the current target.
4. Saturation: drive target to 1000, press up → target stays 1000, no pulso_cambio. From target 5 (MIN_VAL=0, STEP=8), press down → target 0.
5. Both buttons held → no steps. Release up while down stays held → exactly one down step one cycle after the release is debounced, then HOLD timing restarts.
6. Target 80 with cant_corriente at 40 and ramping:
   - Drop enable for 30 cycles → cant_corriente frozen at 40; presses ignored.
   - Raise enable → ramp resumes.
   - Assert reset mid-ramp → both outputs 0 immediately.

Source files
------------

// File: rtl/setpoint_ramp_ctrl_if.sv
// Bundle of button inputs and setpoint outputs for setpoint_ramp_ctrl.
// There is no valid/ready handshake here: the buttons and enable are
// levels sampled every clock, and the outputs are levels, plus one
// single-cycle strobe (pulso_cambio) that marks a change of cant_objetivo.
// fsm_state exposes the repeat FSM (0 IDLE, 1 HOLD, 2 REPEAT) for observation.
interface setpoint_ramp_ctrl_if;
    logic       enable;
    logic       boton_aumento;
    logic       boton_disminuye;
    logic [9:0] cant_objetivo;
    logic [9:0] cant_corriente;
    logic       en_rampa;
    logic       pulso_cambio;
    logic [1:0] fsm_state;

    // Board / test side: drives buttons and enable, watches the setpoint.
    modport master (
        output enable, boton_aumento, boton_disminuye,
        input  cant_objetivo, cant_corriente, en_rampa, pulso_cambio, fsm_state
    );

    // Controller side.
    modport slave (
        input  enable, boton_aumento, boton_disminuye,
        output cant_objetivo, cant_corriente, en_rampa, pulso_cambio, fsm_state
    );
endinterface

// File: rtl/setpoint_ramp_ctrl.sv
// Button-driven setpoint controller for the 10-bit DPWM current setpoint.
// Raw buttons are synchronized and debounced, arbitrated into UP/DN/NONE,
// and turned into saturating target steps with press-and-hold auto-repeat.
// The published setpoint slews toward the target by 1 LSB per ramp tick so
// the PWM comparator never sees a larger step.
module setpoint_ramp_ctrl #(
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 20,
    parameter int REP_CYCLES  = 5,
    parameter int STEP        = 8,
    parameter int MIN_VAL     = 0,
    parameter int MAX_VAL     = 1000,
    parameter int RAMP_DIV    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    setpoint_ramp_ctrl_if.slave  bus
);

    localparam int DW   = $clog2(DEB_CYCLES + 1);
    localparam int TMAX = (HOLD_CYCLES > REP_CYCLES) ? HOLD_CYCLES : REP_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int PW   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_UP   = 2'd1,
        CMD_DN   = 2'd2
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Button index 0 = up, 1 = down.
    logic [1:0]    w_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_deb;
    logic [DW-1:0] r_deb_cnt [2];

    cmd_t          w_cmd;
    state_t        r_state;
    cmd_t          r_cmd_lat;
    logic [TW-1:0] r_timer;
    logic [9:0]    r_obj;
    logic          r_pulse;

    logic [10:0]   w_sum;
    logic [9:0]    w_up_val;
    logic [9:0]    w_dn_val;
    logic [9:0]    w_step_val;
    logic          w_timer_exp;
    logic          w_step_fire;

    logic [PW-1:0] r_pre;
    logic [9:0]    r_cor;
    logic          w_tick;

    assign w_raw = {bus.boton_disminuye, bus.boton_aumento};

    // Two-flop synchronizers followed by counting debouncers; these run
    // regardless of enable so a held button is already resolved when
    // enable comes back.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int i = 0; i < 2; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    // The flip happens on the sample that would bring the
                    // count of disagreeing samples up to DEB_CYCLES.
                    if (r_deb_cnt[i] == DW'(DEB_CYCLES - 1)) begin
                        r_deb[i]     <= r_sync2[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Arbitration: a lone button is a command, both together cancel out.
    always_comb begin
        w_cmd = CMD_NONE;
        if (r_deb[0] && !r_deb[1]) begin
            w_cmd = CMD_UP;
        end else if (r_deb[1] && !r_deb[0]) begin
            w_cmd = CMD_DN;
        end
    end

    // Saturating step arithmetic, carried in 11 bits so the up-sum cannot wrap.
    always_comb begin
        w_sum    = {1'b0, r_obj} + 11'(STEP);
        w_up_val = (w_sum > 11'(MAX_VAL)) ? 10'(MAX_VAL) : w_sum[9:0];
        if ({1'b0, r_obj} < (11'(MIN_VAL) + 11'(STEP))) begin
            w_dn_val = 10'(MIN_VAL);
        end else begin
            w_dn_val = r_obj - 10'(STEP);
        end
        w_step_val = (w_cmd == CMD_UP) ? w_up_val : w_dn_val;
    end

    // A step fires on a fresh command in IDLE, or when the hold/repeat timer
    // runs out while the same command is still present.
    always_comb begin
        w_timer_exp = (r_timer == TW'(1));
        w_step_fire = 1'b0;
        if (bus.enable) begin
            case (r_state)
                ST_IDLE:   w_step_fire = (w_cmd != CMD_NONE);
                ST_HOLD,
                ST_REPEAT: w_step_fire = (w_cmd == r_cmd_lat) && w_timer_exp;
                default:   w_step_fire = 1'b0;
            endcase
        end
    end

    // Repeat FSM together with the target register and its change strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cmd_lat <= CMD_NONE;
            r_timer   <= '0;
            r_obj     <= 10'(MIN_VAL);
            r_pulse   <= 1'b0;
        end else begin
            r_pulse <= 1'b0;
            if (w_step_fire) begin
                r_obj   <= w_step_val;
                r_pulse <= (w_step_val != r_obj);
            end
            if (!bus.enable) begin
                r_state <= ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_cmd != CMD_NONE) begin
                            r_state   <= ST_HOLD;
                            r_cmd_lat <= w_cmd;
                            r_timer   <= TW'(HOLD_CYCLES);
                        end
                    end
                    ST_HOLD, ST_REPEAT: begin
                        if (w_cmd != r_cmd_lat) begin
                            // Any change of command, including to the other
                            // button, goes through IDLE and restarts the timing.
                            r_state <= ST_IDLE;
                        end else if (w_timer_exp) begin
                            r_state <= ST_REPEAT;
                            r_timer <= TW'(REP_CYCLES);
                        end else begin
                            r_timer <= r_timer - 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign w_tick = (r_pre == PW'(RAMP_DIV - 1));

    // Prescaler and 1-LSB slew of the published setpoint; both freeze while
    // disabled. The comparison uses the registered target, so a step landing
    // on the same edge only affects the following tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre <= '0;
            r_cor <= 10'(MIN_VAL);
        end else if (bus.enable) begin
            if (w_tick) begin
                r_pre <= '0;
                if (r_cor < r_obj) begin
                    r_cor <= r_cor + 1'b1;
                end else if (r_cor > r_obj) begin
                    r_cor <= r_cor - 1'b1;
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    assign bus.cant_objetivo  = r_obj;
    assign bus.cant_corriente = r_cor;
    assign bus.en_rampa       = (r_cor != r_obj);
    assign bus.pulso_cambio   = r_pulse;
    assign bus.fsm_state      = r_state;

endmodule
